// File: rtl/sl_pkg.sv
// Shared serial-line definitions: config layout, reset value and FSM encoding.
// Config bit 14 (parity) is only writable when SL_TX_PARITY_EN is defined.
package sl_pkg;

    localparam int unsigned CfgDivLsb  = 0;
    localparam int unsigned CfgDivMsb  = 7;
    localparam int unsigned CfgWlenLsb = 8;
    localparam int unsigned CfgWlenMsb = 13;
    localparam int unsigned CfgParBit  = 14;
    localparam int unsigned CfgRsvBit  = 15;

    localparam int unsigned WlenMin = 8;
    localparam int unsigned WlenMax = 32;

    // Enough for 15 gap bits x 2 phases x 256 clocks.
    localparam int unsigned IfgCntW = $clog2(15 * 2 * 256 + 1);

`ifdef SL_TX_PARITY_EN
    localparam logic [15:0] CfgReset  = 16'h600F;
    localparam logic [15:0] CfgWrMask = 16'h7FFF;
`else
    localparam logic [15:0] CfgReset  = 16'h200F;
    localparam logic [15:0] CfgWrMask = 16'h3FFF;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap,
        StIfg
    } sl_state_e;

    function automatic logic [5:0] clamp_wlen(input logic [5:0] wlen);
        logic [5:0] res;
        res = wlen;
        if (wlen < 6'(WlenMin)) begin
            res = 6'(WlenMin);
        end else if (wlen > 6'(WlenMax)) begin
            res = 6'(WlenMax);
        end
        return res;
    endfunction

endpackage

// File: rtl/sl_tx_channel_phase_timer.sv
// Loadable down-counter with terminal-count flag; holds at zero until reloaded.
module sl_phase_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/sl_tx_channel.sv
// Serial-line transmitter: 32-bit word out as return-to-zero pulses on sl1/sl0.
// Define SL_TX_PARITY_EN to build the optional odd-parity bit.
module sl_tx_channel
    import sl_pkg::*;
#(
    parameter int unsigned CONFIG_REG_WIDTH = 16,
    parameter int unsigned IFG_BITS         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 wr_data,
    input  logic                        data_we,
    input  logic [CONFIG_REG_WIDTH-1:0] wr_config,
    input  logic                        config_we,
    output logic [CONFIG_REG_WIDTH-1:0] rd_config,
    output logic                        rd_status,
    output logic                        status_changed,
    output logic                        sl0,
    output logic                        sl1
);

    sl_state_e state_q, state_d;

    logic [CONFIG_REG_WIDTH-1:0] cfg_q, cfg_d;
    logic [31:0]                 data_q, data_d;
    logic [7:0]                  div_q, div_d;
    logic [5:0]                  wlen_q, wlen_d;
    logic [5:0]                  bit_cnt_q, bit_cnt_d;
    logic                        sl0_q, sl0_d, sl1_q, sl1_d;
    logic                        status_q, status_d;
    logic                        status_chg_q, status_chg_d;

    logic [5:0]         wlen_in;
    logic [5:0]         total_bits;
    logic               cur_bit;
    logic               ph_load, ph_tc, ifg_load, ifg_tc;
    logic [7:0]         ph_val, ph_count;
    logic [IfgCntW-1:0] ifg_val, ifg_count;

    assign wlen_in = clamp_wlen(cfg_q[CfgWlenMsb:CfgWlenLsb]);
    assign ifg_val = IfgCntW'(IFG_BITS * 2 * (32'(div_q) + 32'd1) - 32'd1);

`ifdef SL_TX_PARITY_EN
    logic        par_en_q, par_en_d;
    logic        parity_q, parity_d;
    logic [31:0] word_mask;
    logic        word_par;

    // Shift of 32 wraps to zero, so the subtraction yields the full mask.
    assign word_mask  = (32'h1 << wlen_in) - 32'h1;
    assign word_par   = ~^(wr_data & word_mask);
    assign total_bits = wlen_q + {5'b0, par_en_q};
    assign cur_bit    = (bit_cnt_q < wlen_q) ? data_q[0] : parity_q;
`else
    assign total_bits = wlen_q;
    assign cur_bit    = data_q[0];
`endif

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        data_d    = data_q;
        div_d     = div_q;
        wlen_d    = wlen_q;
        bit_cnt_d = bit_cnt_q;
        sl0_d     = 1'b0;
        sl1_d     = 1'b0;
        ph_load   = 1'b0;
        ph_val    = div_q;
        ifg_load  = 1'b0;
`ifdef SL_TX_PARITY_EN
        par_en_d  = par_en_q;
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (config_we) begin
                    cfg_d = wr_config & CfgWrMask;
                end
                // Fields latch from the current register, so a simultaneous
                // config write only affects the next word.
                if (data_we) begin
                    state_d   = StPulse;
                    data_d    = wr_data;
                    div_d     = cfg_q[CfgDivMsb:CfgDivLsb];
                    wlen_d    = wlen_in;
                    bit_cnt_d = '0;
                    ph_load   = 1'b1;
                    ph_val    = cfg_q[CfgDivMsb:CfgDivLsb];
                    sl1_d     = wr_data[0];
                    sl0_d     = ~wr_data[0];
`ifdef SL_TX_PARITY_EN
                    par_en_d  = cfg_q[CfgParBit];
                    parity_d  = word_par;
`endif
                end
            end
            StPulse: begin
                if (ph_tc) begin
                    state_d   = StGap;
                    ph_load   = 1'b1;
                    data_d    = data_q >> 1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else begin
                    sl1_d = cur_bit;
                    sl0_d = ~cur_bit;
                end
            end
            StGap: begin
                if (ph_tc) begin
                    if (bit_cnt_q < total_bits) begin
                        state_d = StPulse;
                        ph_load = 1'b1;
                        sl1_d   = cur_bit;
                        sl0_d   = ~cur_bit;
                    end else begin
                        state_d  = StIfg;
                        ifg_load = 1'b1;
                    end
                end
            end
            StIfg: begin
                if (ifg_tc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign status_d     = (state_d != StIdle);
    assign status_chg_d = (status_d != status_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cfg_q        <= CfgReset;
            data_q       <= '0;
            div_q        <= '0;
            wlen_q       <= 6'(WlenMin);
            bit_cnt_q    <= '0;
            sl0_q        <= 1'b0;
            sl1_q        <= 1'b0;
            status_q     <= 1'b0;
            status_chg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            data_q       <= data_d;
            div_q        <= div_d;
            wlen_q       <= wlen_d;
            bit_cnt_q    <= bit_cnt_d;
            sl0_q        <= sl0_d;
            sl1_q        <= sl1_d;
            status_q     <= status_d;
            status_chg_q <= status_chg_d;
        end
    end

`ifdef SL_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
            parity_q <= parity_d;
        end
    end
`endif

    sl_phase_timer #(
        .Width(8)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ph_load),
        .load_val_i(ph_val),
        .count_o   (ph_count),
        .tc_o      (ph_tc)
    );

    sl_phase_timer #(
        .Width(IfgCntW)
    ) u_ifg_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ifg_load),
        .load_val_i(ifg_val),
        .count_o   (ifg_count),
        .tc_o      (ifg_tc)
    );

    logic unused_counts;
    assign unused_counts = ^{ph_count, ifg_count};

    assign rd_config      = cfg_q;
    assign rd_status      = status_q;
    assign status_changed = status_chg_q;
    assign sl0            = sl0_q;
    assign sl1            = sl1_q;

endmodule
